sysid_check: RTL and testbench
==============================

# sysid_check

Avalon-MM read master sitting directly upstream of the system-ID slave. After reset release, or on a start pulse, it reads word 0 (system ID) and then word 1 (build timestamp) from the slave. It compares both words against build-time expected values and reports pass/fail flags to the boot/status logic. A blank or mismatched image is thereby caught in hardware before the Nios II software relies on it.

## Interface
- EXPECTED_ID, default 32'd0: required value of word 0.
- EXPECTED_TIMESTAMP, default 32'd1543892682: required value of word 1.
- READ_LATENCY, default 0: slave read latency in cycles. Legal range 0–3.
- TIMEOUT_CYCLES, default 255: maximum cycles a read may stall on waitrequest. Range 1–65535.
- AUTO_START, default 1: 1 = run one check automatically after reset release.

Ports:
- clock, input, 1: single clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous assert, active-low reset.
- start, input, 1: single-cycle request to run a check. Ignored while busy.
- avm_address, output, 1: word address to the slave (0 = ID, 1 = timestamp).
- avm_read, output, 1: read strobe.
- avm_waitrequest, input, 1: slave stall. Tie 0 for a slave without waitrequest.
- avm_readdata, input, 32: read data.
- id_value, output, 32: captured word 0.
- timestamp_value, output, 32: captured word 1.
- busy, output, 1: check in progress.
- done, output, 1: one-cycle pulse when a check ends, by completion or timeout.
- match, output, 1: sticky; 1 = last check read both words and both equal the expected values.
- timeout, output, 1: sticky; 1 = last check aborted on a waitrequest stall.

## Operation
- Reset value of every output is 0. All internal state is cleared, including the FSM (IDLE), the stall counter and the latency counter.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- Entering a check:
  - IDLE -> RD_ID when start=1, or on the first cycle after reset deassertion if AUTO_START=1 (one-shot flag).
  - On entry, match and timeout clear and busy sets.
- RD_ID:
  - Drives avm_read=1, avm_address=0.
  - Acceptance = avm_read & ~avm_waitrequest at a clock edge.
  - On acceptance with READ_LATENCY=0: capture avm_readdata into id_value and go to RD_TS.
  - On acceptance with READ_LATENCY>0: go to LAT_ID.
- LAT_ID:
  - avm_read=0. Counts READ_LATENCY edges, captures avm_readdata on the last one, then goes to RD_TS.
- RD_TS / LAT_TS: identical flow with address 1, capturing into timestamp_value, then go to FINISH.
- FINISH (one cycle):
  - match <= (id_value==EXPECTED_ID) & (timestamp_value==EXPECTED_TIMESTAMP).
  - done=1, busy<=0, then IDLE.
- Stall counter:
  - 16 bits. Cleared on entry to RD_ID and RD_TS; increments each edge with avm_read & avm_waitrequest.
  - When the count reaches TIMEOUT_CYCLES and waitrequest is still high: drop avm_read, set timeout=1, match=0, pulse done, busy<=0, return to IDLE.
  - id_value/timestamp_value keep their last captured contents.
- Address and read stability: avm_address and avm_read are registered and held stable while waitrequest=1.
- Simultaneous events:
  - start while busy: ignored, not queued.
  - start in the FINISH cycle: ignored.
  - start in the cycle after done: accepted.
- Reset mid-read: all outputs go to 0 immediately (asynchronous). After release, the check re-runs only if AUTO_START=1.

## Timing
- READ_LATENCY=0, waitrequest=0, start sampled at edge 0:
  - busy=1 and avm_read=1 (addr 0) after edge 0.
  - ID captured at edge 1; addr 1 after edge 1.
  - Timestamp captured at edge 2.
  - done=1 and match valid after edge 3.
  - Total: 3 cycles start-to-done.
- Each waitrequest stall cycle adds 1 cycle. Each read adds READ_LATENCY cycles.
- Timeout path: done asserts TIMEOUT_CYCLES+1 cycles after the stalled read began.
- match/timeout: change only on check entry (clear) and at done. Valid from the done cycle until the next check starts.

## Test plan
- Auto-start, zero latency, slave returns 0 / 1543892682:
  - No start pulse needed. done pulses once on cycle 3 after reset release.
  - match=1, timeout=0, id_value=0, timestamp_value=1543892682.
- Mismatch on word 1 only (slave returns 0 / 0x12345678) -> match=0, timeout=0, timestamp_value=0x12345678.
- READ_LATENCY=2, waitrequest high 3 cycles on word 0:
  - Start-to-done = 3+3+4 = 10 cycles.
  - avm_address holds 0 during the stall; correct values captured.
- TIMEOUT_CYCLES=8, waitrequest held high forever:
  - done after 9 cycles in RD_ID, timeout=1, match=0, avm_read=0 afterwards.
  - A later start with waitrequest=0 clears timeout and passes.
- start pulsed while busy, then again in the cycle after done -> exactly two checks run, two done pulses.
- reset_n asserted during LAT_TS, AUTO_START=0:
  - All outputs 0 immediately; avm_read stays 0 after release until start.

Source files
------------

// File: rtl/sysid_check.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words
// from the sysid slave and flags whether both match the build-time values.
module sysid_check #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1543892682,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT_CYCLES);
  localparam bit          HAS_LAT_C  = (READ_LATENCY != 0);
  localparam logic [1:0]  LAT_LAST_C = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      state_r;
  logic        auto_pending_r;
  logic [15:0] stall_cnt_r;
  logic [1:0]  lat_cnt_r;

  logic accept_s;
  logic stall_s;
  logic stall_limit_s;
  logic start_req_s;
  logic lat_last_s;

  assign accept_s      = avm_read & ~avm_waitrequest;
  assign stall_s       = avm_read & avm_waitrequest;
  assign stall_limit_s = (stall_cnt_r == TIMEOUT_C);
  assign start_req_s   = start | auto_pending_r;
  assign lat_last_s    = (lat_cnt_r == LAT_LAST_C);

  // Check sequencer: issues both reads, tracks stalls/latency, grades the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      auto_pending_r  <= AUTO_START;
      stall_cnt_r     <= 16'd0;
      lat_cnt_r       <= 2'd0;
      avm_address     <= 1'b0;
      avm_read        <= 1'b0;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_req_s) begin
            state_r        <= RD_ID;
            auto_pending_r <= 1'b0;
            busy           <= 1'b1;
            match          <= 1'b0;
            timeout        <= 1'b0;
            avm_read       <= 1'b1;
            avm_address    <= 1'b0;
            stall_cnt_r    <= 16'd0;
          end else begin
            state_r <= IDLE;
          end
        end

        RD_ID: begin
          if (accept_s) begin
            if (HAS_LAT_C) begin
              avm_read  <= 1'b0;
              lat_cnt_r <= 2'd0;
              state_r   <= LAT_ID;
            end else begin
              id_value    <= avm_readdata;
              avm_address <= 1'b1;
              stall_cnt_r <= 16'd0;
              state_r     <= RD_TS;
            end
          end else if (stall_s) begin
            // Abort only once the limit is reached and the slave is still stalling.
            if (stall_limit_s) begin
              avm_read    <= 1'b0;
              avm_address <= 1'b0;
              timeout     <= 1'b1;
              match       <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state_r     <= IDLE;
            end else begin
              stall_cnt_r <= stall_cnt_r + 16'd1;
            end
          end else begin
            state_r <= RD_ID;
          end
        end

        LAT_ID: begin
          if (lat_last_s) begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            stall_cnt_r <= 16'd0;
            state_r     <= RD_TS;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end

        RD_TS: begin
          if (accept_s) begin
            avm_read <= 1'b0;
            if (HAS_LAT_C) begin
              lat_cnt_r <= 2'd0;
              state_r   <= LAT_TS;
            end else begin
              timestamp_value <= avm_readdata;
              state_r         <= FINISH;
            end
          end else if (stall_s) begin
            if (stall_limit_s) begin
              avm_read    <= 1'b0;
              avm_address <= 1'b0;
              timeout     <= 1'b1;
              match       <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state_r     <= IDLE;
            end else begin
              stall_cnt_r <= stall_cnt_r + 16'd1;
            end
          end else begin
            state_r <= RD_TS;
          end
        end

        LAT_TS: begin
          if (lat_last_s) begin
            timestamp_value <= avm_readdata;
            state_r         <= FINISH;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end

        FINISH: begin
          match       <= (id_value == EXPECTED_ID) & (timestamp_value == EXPECTED_TIMESTAMP);
          done        <= 1'b1;
          busy        <= 1'b0;
          avm_address <= 1'b0;
          state_r     <= IDLE;
        end

        default: begin
          state_r     <= IDLE;
          avm_read    <= 1'b0;
          avm_address <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check.sv
// Bench for sysid_check: two instances (zero-latency auto-start, and
// latency-2/short-timeout manual-start) each fed by a small slave model.
module tb_sysid_check;

  localparam logic [31:0] TS_A = 32'd1543892682;
  localparam logic [31:0] ID_B = 32'h1234_0042;
  localparam logic [31:0] TS_B = 32'h6000_0001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, wr_a, addr_a, read_a, busy_a, done_a, match_a, tout_a;
  logic [31:0] rdata_a, id_a, ts_a;
  logic        start_b, wr_b, addr_b, read_b, busy_b, done_b, match_b, tout_b;
  logic [31:0] rdata_b, id_b, ts_b;

  logic [31:0] mem_a [2];
  logic [31:0] mem_b [2];
  logic [1:0]  pv_b = 2'b00;
  logic [1:0]  pa_b = 2'b00;

  sysid_check dut_a (
    .clock(clk), .reset_n(rst_n), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
    .id_value(id_a), .timestamp_value(ts_a), .busy(busy_a), .done(done_a),
    .match(match_a), .timeout(tout_a)
  );

  sysid_check #(
    .EXPECTED_ID(ID_B), .EXPECTED_TIMESTAMP(TS_B),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
    .id_value(id_b), .timestamp_value(ts_b), .busy(busy_b), .done(done_b),
    .match(match_b), .timeout(tout_b)
  );

  // Slave models: zero-latency for A, two-cycle fixed latency for B (garbage otherwise).
  assign rdata_a = (read_a & ~wr_a) ? mem_a[addr_a] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    pv_b <= {pv_b[0], read_b & ~wr_b};
    pa_b <= {pa_b[0], addr_b};
  end
  assign rdata_b = pv_b[1] ? mem_b[pa_b[1]] : 32'hDEAD_BEEF;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        m;
    logic        t;
    int          done_at;
  } exp_t;
  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        m;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) chk("spurious_done_a", 32'd1, 32'd0);
      else begin
        ea = q_a.pop_front();
        chk("done_cycle_a", ecnt, ea.done_at);
        chk("id_a", id_a, ea.id);
        chk("ts_a", ts_a, ea.ts);
        chk("match_a", {31'd0, match_a}, {31'd0, ea.m});
        chk("timeout_a", {31'd0, tout_a}, {31'd0, ea.t});
        chk("busy_at_done_a", {31'd0, busy_a}, 32'd0);
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) chk("spurious_done_b", 32'd1, 32'd0);
      else begin
        eb = q_b.pop_front();
        chk("done_cycle_b", ecnt, eb.done_at);
        chk("id_b", id_b, eb.id);
        chk("ts_b", ts_b, eb.ts);
        chk("match_b", {31'd0, match_b}, {31'd0, eb.m});
        chk("timeout_b", {31'd0, tout_b}, {31'd0, eb.t});
        chk("busy_at_done_b", {31'd0, busy_b}, 32'd0);
      end
    end
  end

  task automatic wait_q(input bit which_b, input int bound);
    int n = 0;
    while (((which_b ? q_b.size() : q_a.size()) != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (which_b) begin
      chk("wait_bound_b", q_b.size(), 32'd0);
      q_b.delete();
    end else begin
      chk("wait_bound_a", q_a.size(), 32'd0);
      q_a.delete();
    end
    @(negedge clk);
  endtask

  task automatic kick_a(input logic [31:0] id, input logic [31:0] ts, input logic m);
    start_a = 1'b1;
    q_a.push_back('{id, ts, m, 1'b0, ecnt + 4});
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic kick_b(input logic [31:0] id, input logic [31:0] ts, input logic m,
                        input logic t, input int lat);
    start_b = 1'b1;
    q_b.push_back('{id, ts, m, t, ecnt + 1 + lat});
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_a"},  {31'd0, addr_a},  32'd0);
    chk({tag, "_read_a"},  {31'd0, read_a},  32'd0);
    chk({tag, "_id_a"},    id_a,             32'd0);
    chk({tag, "_ts_a"},    ts_a,             32'd0);
    chk({tag, "_busy_a"},  {31'd0, busy_a},  32'd0);
    chk({tag, "_done_a"},  {31'd0, done_a},  32'd0);
    chk({tag, "_match_a"}, {31'd0, match_a}, 32'd0);
    chk({tag, "_tout_a"},  {31'd0, tout_a},  32'd0);
    chk({tag, "_addr_b"},  {31'd0, addr_b},  32'd0);
    chk({tag, "_read_b"},  {31'd0, read_b},  32'd0);
    chk({tag, "_id_b"},    id_b,             32'd0);
    chk({tag, "_ts_b"},    ts_b,             32'd0);
    chk({tag, "_busy_b"},  {31'd0, busy_b},  32'd0);
    chk({tag, "_done_b"},  {31'd0, done_b},  32'd0);
    chk({tag, "_match_b"}, {31'd0, match_b}, 32'd0);
    chk({tag, "_tout_b"},  {31'd0, tout_b},  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd0,         TS_A,          1'b1};
    vecs[1] = '{32'd0,         32'h1234_5678, 1'b0};
    vecs[2] = '{32'd1,         TS_A,          1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'd0,         TS_A,          1'b1};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    mem_a[0] = 32'd0; mem_a[1] = TS_A;
    mem_b[0] = ID_B;  mem_b[1] = TS_B;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Auto-start on A only; B must stay idle.
    rst_n = 1'b1;
    q_a.push_back('{32'd0, TS_A, 1'b1, 1'b0, ecnt + 4});
    wait_q(1'b0, 20);
    chk("b_idle_read", {31'd0, read_b}, 32'd0);
    chk("b_idle_busy", {31'd0, busy_b}, 32'd0);

    // Table-driven checks on A.
    for (int i = 0; i < 5; i++) begin
      mem_a[0] = vecs[i].id;
      mem_a[1] = vecs[i].ts;
      kick_a(vecs[i].id, vecs[i].ts, vecs[i].m);
      wait_q(1'b0, 20);
    end

    // start while busy and during FINISH ignored; start in the cycle after done accepted.
    start_a = 1'b1;
    q_a.push_back('{32'd0, TS_A, 1'b1, 1'b0, ecnt + 4});
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    q_a.push_back('{32'd0, TS_A, 1'b1, 1'b0, ecnt + 4});
    @(negedge clk); start_a = 1'b0;
    wait_q(1'b0, 20);
    repeat (4) @(negedge clk);

    // B: latency 2 with three stall cycles on word 0; address must hold.
    wr_b = 1'b1;
    start_b = 1'b1;
    q_b.push_back('{ID_B, TS_B, 1'b1, 1'b0, ecnt + 11});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      chk("stall_read_b", {31'd0, read_b}, 32'd1);
      chk("stall_addr_b", {31'd0, addr_b}, 32'd0);
    end
    wr_b = 1'b0;
    wait_q(1'b1, 30);

    // B: waitrequest stuck high -> timeout; captured words unchanged.
    wr_b = 1'b1;
    kick_b(ID_B, TS_B, 1'b0, 1'b1, 9);
    wait_q(1'b1, 30);
    @(negedge clk);
    chk("post_tout_read_b", {31'd0, read_b}, 32'd0);
    chk("post_tout_sticky_b", {31'd0, tout_b}, 32'd1);
    chk("post_tout_busy_b", {31'd0, busy_b}, 32'd0);
    wr_b = 1'b0;
    kick_b(ID_B, TS_B, 1'b1, 1'b0, 7);
    wait_q(1'b1, 30);

    // B: reset asserted while in LAT_TS.
    mem_b[0] = 32'hA5A5_0001;
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("latts_busy_b", {31'd0, busy_b}, 32'd1);
    chk("latts_addr_b", {31'd0, addr_b}, 32'd1);
    chk("latts_read_b", {31'd0, read_b}, 32'd0);
    chk("latts_id_b", id_b, 32'hA5A5_0001);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    mem_a[0] = 32'd0; mem_a[1] = TS_A;
    rst_n = 1'b1;
    q_a.push_back('{32'd0, TS_A, 1'b1, 1'b0, ecnt + 4});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_autostart_read_b", {31'd0, read_b}, 32'd0);
    end
    wait_q(1'b0, 20);
    mem_b[0] = ID_B;
    kick_b(ID_B, TS_B, 1'b1, 1'b0, 7);
    wait_q(1'b1, 30);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
